// File: rtl/fan_pkg.sv
// Shared fan definitions: speed state encoding and default battery threshold.
package fan_pkg;

    localparam int unsigned STATE_W        = 2;
    localparam int unsigned LOW_THRESH_DEF = 10;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_LOW  = 2'b01,
        ST_MID  = 2'b10,
        ST_HIGH = 2'b11
    } fan_state_t;

    // Normal mode-button rotation idle->low->mid->high->idle.
    function automatic fan_state_t next_speed(input fan_state_t s);
        fan_state_t n;
        n = ST_IDLE;
        case (s)
            ST_IDLE: n = ST_LOW;
            ST_LOW:  n = ST_MID;
            ST_MID:  n = ST_HIGH;
            ST_HIGH: n = ST_IDLE;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchroniser, level debouncer, rising-edge press pulse.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             w_diff;
    logic             w_done;

    assign w_diff  = (r_sync2 != r_level);
    assign w_done  = (r_cnt == CNT_W'(DEB_CYCLES - 1));
    assign o_press = r_press;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive samples that disagree with the accepted level; flip on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fan_mode_controller.sv
// Fan speed controller: button-driven speed FSM with battery throttling and 100/200 ms ticks.
module fan_mode_controller
    import fan_pkg::*;
#(
    parameter int unsigned TICKS_100MS = 5_000_000,
    parameter int unsigned DEB_CYCLES  = 1_000_000,
    parameter int unsigned LOW_THRESH  = LOW_THRESH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_off,
    input  logic [7:0] battery,
    input  logic       battery_empty,
    output logic [1:0] state,
    output logic       timer_100ms,
    output logic       timer_200ms,
    output logic       low_batt
);

    localparam int unsigned PRE_W = (TICKS_100MS > 1) ? $clog2(TICKS_100MS) : 1;

    logic [PRE_W-1:0] r_pre;
    logic             r_tog;
    logic             r_t100;
    logic             r_t200;
    logic             r_low_batt;
    fan_state_t       r_state;
    logic             w_wrap;
    logic             w_mode_press;
    logic             w_off_press;

    assign w_wrap      = (r_pre == PRE_W'(TICKS_100MS - 1));
    assign state       = r_state;
    assign timer_100ms = r_t100;
    assign timer_200ms = r_t200;
    assign low_batt    = r_low_batt;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_mode),
        .o_press (w_mode_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_off (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_off),
        .o_press (w_off_press)
    );

    // Free-running prescaler; the toggle selects every second 100 ms tick for the 200 ms pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_tog  <= 1'b0;
            r_t100 <= 1'b0;
            r_t200 <= 1'b0;
        end else begin
            r_t100 <= w_wrap;
            r_t200 <= w_wrap & r_tog;
            if (w_wrap) begin
                r_pre <= '0;
                r_tog <= ~r_tog;
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
        end
    end

    // Low-battery flag; values above 99 simply compare as not-low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low_batt <= 1'b0;
        end else begin
            r_low_batt <= (battery < 8'(LOW_THRESH));
        end
    end

    // Speed FSM: empty battery beats off, off beats mode, low battery caps speed at low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (battery_empty) begin
            r_state <= ST_IDLE;
        end else if (w_off_press) begin
            r_state <= ST_IDLE;
        end else if (w_mode_press) begin
            if (r_low_batt) begin
                r_state <= (r_state == ST_LOW) ? ST_IDLE : ST_LOW;
            end else begin
                r_state <= next_speed(r_state);
            end
        end else if (r_low_batt && ((r_state == ST_MID) || (r_state == ST_HIGH))) begin
            r_state <= ST_LOW;
        end
    end

endmodule

// File: tb/tb_fan_mode_controller.sv
// Randomised bench for fan_mode_controller with a cycle-level behavioural reference model.
module tb_fan_mode_controller;

    localparam int TICKS = 10;
    localparam int DEB   = 4;
    localparam int THR   = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_off;
    logic [7:0] battery;
    logic       battery_empty;
    logic [1:0] state;
    logic       timer_100ms;
    logic       timer_200ms;
    logic       low_batt;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int n_edge;
    bit hist_m[$];
    bit hist_o[$];
    int sp;
    bit lb, pm, po, lvl_m, lvl_o;

    fan_mode_controller #(
        .TICKS_100MS (TICKS),
        .DEB_CYCLES  (DEB),
        .LOW_THRESH  (THR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_mode      (btn_mode),
        .btn_off       (btn_off),
        .battery       (battery),
        .battery_empty (battery_empty),
        .state         (state),
        .timer_100ms   (timer_100ms),
        .timer_200ms   (timer_200ms),
        .low_batt      (low_batt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // True when the last DEB synchronised samples (raw delayed two edges) all oppose lvl.
    function automatic bit deb_flip(input bit q[$], input int e, input bit lvl);
        bit s;
        if (e < DEB) return 1'b0;
        for (int k = 0; k < DEB; k++) begin
            s = (e - k >= 3) ? q[e - k - 3] : 1'b0;
            if (s == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        n_edge = 0;
        hist_m.delete();
        hist_o.delete();
        sp = 0; lb = 0; pm = 0; po = 0; lvl_m = 0; lvl_o = 0;
    endtask

    // Advance model by one clock using the current inputs, then compare against the DUT.
    task automatic step();
        n_edge++;
        hist_m.push_back(btn_mode);
        hist_o.push_back(btn_off);
        if (battery_empty)   sp = 0;
        else if (po)         sp = 0;
        else if (pm)         sp = lb ? ((sp == 1) ? 0 : 1) : (sp + 1) % 4;
        else if (lb && sp > 1) sp = 1;
        lb = (int'(battery) < THR);
        pm = 0;
        po = 0;
        if (deb_flip(hist_m, n_edge, lvl_m)) begin lvl_m = !lvl_m; pm = lvl_m; end
        if (deb_flip(hist_o, n_edge, lvl_o)) begin lvl_o = !lvl_o; po = lvl_o; end
        @(posedge clk);
        #1;
        check("state",    int'(state),       sp);
        check("t100",     int'(timer_100ms), (n_edge % TICKS == 0) ? 1 : 0);
        check("t200",     int'(timer_200ms), (n_edge % (2 * TICKS) == 0) ? 1 : 0);
        check("low_batt", int'(low_batt),    lb ? 1 : 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_state", int'(state),       0);
        check("rst_t100",  int'(timer_100ms), 0);
        check("rst_t200",  int'(timer_200ms), 0);
        check("rst_lowb",  int'(low_batt),    0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        repeat (8) step();
        btn_mode = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        int c100, c200, mrem, orem;
        rst_n = 1'b0; btn_mode = 1'b0; btn_off = 1'b0;
        battery = 8'd50; battery_empty = 1'b0;
        do_reset();

        // timer cadence
        c100 = 0; c200 = 0;
        repeat (60) begin
            step();
            c100 += int'(timer_100ms);
            c200 += int'(timer_200ms);
        end
        check("t100_count", c100, 6);
        check("t200_count", c200, 3);

        // glitch rejected, long hold gives one step
        btn_mode = 1'b1; repeat (3) step(); btn_mode = 1'b0; repeat (10) step();
        check("glitch", int'(state), 0);
        btn_mode = 1'b1; repeat (20) step(); btn_mode = 1'b0; repeat (8) step();
        check("hold_once", int'(state), 1);

        // rotation and off
        press_mode(); check("rot_mid",  int'(state), 2);
        press_mode(); check("rot_high", int'(state), 3);
        press_mode(); check("rot_idle", int'(state), 0);
        press_mode(); check("rot_low",  int'(state), 1);
        press_mode(); check("rot_mid2", int'(state), 2);
        btn_off = 1'b1; repeat (8) step(); btn_off = 1'b0; repeat (8) step();
        check("off", int'(state), 0);

        // low battery throttle, no restore
        press_mode(); press_mode(); press_mode();
        check("pre_low_high", int'(state), 3);
        battery = 8'd9;
        step(); check("lowb_set", int'(low_batt), 1); check("lowb_hold", int'(state), 3);
        step(); check("lowb_force", int'(state), 1);
        battery = 8'd50;
        repeat (5) step(); check("lowb_norestore", int'(state), 1);

        // empty battery beats a coincident press and discards later presses
        press_mode(); check("pre_empty_mid", int'(state), 2);
        btn_mode = 1'b1; repeat (6) step();
        battery_empty = 1'b1;
        step(); check("empty_vs_press", int'(state), 0);
        btn_mode = 1'b0; repeat (6) step();
        press_mode(); press_mode();
        check("empty_discard", int'(state), 0);
        battery_empty = 1'b0;
        repeat (4) step(); check("empty_noqueue", int'(state), 0);

        // random traffic
        mrem = 0; orem = 0;
        repeat (1500) begin
            if (mrem == 0) begin btn_mode = 1'($urandom_range(0, 1)); mrem = $urandom_range(1, 14); end
            if (orem == 0) begin btn_off = ($urandom_range(0, 5) == 0); orem = $urandom_range(1, 20); end
            mrem--; orem--;
            if ($urandom_range(0, 40) == 0)
                battery = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(90, 255)) : 8'($urandom_range(0, 30));
            if ($urandom_range(0, 80) == 0) battery_empty = ~battery_empty;
            step();
        end

        // reset mid-count while at high speed
        btn_mode = 1'b0; btn_off = 1'b0; battery = 8'd50; battery_empty = 1'b0;
        do_reset();
        press_mode(); press_mode(); press_mode();
        check("pre_rst_high", int'(state), 3);
        repeat (4) step();
        do_reset();
        repeat (12) step();

        // press held across reset release gives one event
        btn_mode = 1'b1;
        do_reset();
        repeat (20) step();
        btn_mode = 1'b0;
        repeat (6) step();
        check("held_through_reset", int'(state), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
